tr_step_monitor: RTL and testbench

//  Receive-side monitor for the stepper drive interface produced by TR_pulse (drv_step, drv_dir, drv_en_SM).

---
 rtl/tr_step_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_tr_step_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tr_step_monitor.sv
// tr_step_monitor: receive-side decoder for the TR_pulse stepper drive lines.
// Rebuilds a signed step position and a step period in clk cycles from the
// drv_step/drv_dir/drv_en_SM pins, and flags stalls and short step pulses.
// Optional direction setup check: define TR_STEP_MON_DIR_CHECK_EN to enable
// it; otherwise dir_err is tied low.
module tr_step_monitor #(
  parameter int PERIOD_W  = 17,
  parameter int POS_W     = 32,
  parameter int TIMEOUT   = 100000,
  parameter int MIN_HIGH  = 2,
  parameter int DIR_SETUP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       drv_step,
  input  logic                       drv_dir,
  input  logic                       drv_en_SM,
  input  logic                       clr_pos,
  output logic signed [POS_W-1:0]    position,
  output logic        [PERIOD_W-1:0] period_out,
  output logic                       period_valid,
  output logic                       step_seen,
  output logic                       stall,
  output logic                       glitch_err,
  output logic                       dir_err
);

  localparam int HW = $clog2(MIN_HIGH + 2);
  localparam logic [PERIOD_W-1:0] TO_VAL = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN, S_STALL} state_t;

  // Period counter increment that holds at full scale instead of wrapping.
  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == '1) ? v : v + PERIOD_W'(1);
  endfunction

  logic                       r_step_s1, r_step_s2, r_step_s3;
  logic                       r_dir_s1, r_dir_s2;
  logic                       r_en_s1, r_en_s2;
  logic [HW-1:0]              r_hi_cnt;
  logic [PERIOD_W-1:0]        r_cnt;
  state_t                     r_state, w_state_nxt;
  logic                       w_accept, w_timeout, w_period_upd;
  logic                       w_rise, w_fall, w_short;
  logic signed [POS_W-1:0]    w_pos_base, w_pos_delta, w_pos_next;
  logic signed [POS_W-1:0]    r_position;
  logic [PERIOD_W-1:0]        r_period;
  logic                       r_period_valid, r_step_seen, r_stall, r_glitch_err;

  assign w_rise  = r_step_s2 & ~r_step_s3;
  assign w_fall  = ~r_step_s2 & r_step_s3;
  assign w_short = (r_hi_cnt < HW'(MIN_HIGH));

  // Pin synchronizers; no reset so the pins keep flowing through during rst.
  always_ff @(posedge clk) begin
    r_step_s1 <= drv_step;
    r_step_s2 <= r_step_s1;
    r_step_s3 <= r_step_s2;
    r_dir_s1  <= drv_dir;
    r_dir_s2  <= r_dir_s1;
    r_en_s1   <= drv_en_SM;
    r_en_s2   <= r_en_s1;
  end

  // Synchronized step high-time, saturating at MIN_HIGH; read at the falling edge.
  always_ff @(posedge clk) begin
    if (w_rise)
      r_hi_cnt <= HW'(1);
    else if (r_step_s2 && w_short)
      r_hi_cnt <= r_hi_cnt + HW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus edge-accept / timeout decode; disable wins from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    if (!r_en_s2) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FIRST;
        S_FIRST: if (w_rise) begin
                   w_accept    = 1'b1;
                   w_state_nxt = S_RUN;
                 end
        S_RUN:   if (w_rise) begin
                   w_accept = 1'b1;
                 end else if (r_cnt == TO_VAL) begin
                   w_timeout   = 1'b1;
                   w_state_nxt = S_STALL;
                 end
        S_STALL: if (w_rise) begin
                   w_accept    = 1'b1;
                   w_state_nxt = S_RUN;
                 end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A period is only measurable between two edges both seen while running.
  assign w_period_upd = w_accept && (r_state == S_RUN);

  // Clear-then-count: a coincident clr_pos zeroes the base before the step applies.
  always_comb begin
    w_pos_base  = clr_pos ? '0 : r_position;
    w_pos_delta = r_dir_s2 ? POS_W'(1) : '1;
    w_pos_next  = w_pos_base + w_pos_delta;
  end

  // Cycles since the last accepted edge; zero whenever the monitor is disabled.
  always_ff @(posedge clk) begin
    if (rst || !r_en_s2)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= PERIOD_W'(1);
    else if (r_state == S_RUN)
      r_cnt <= sat_inc(r_cnt);
  end

  // Position, period and per-edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_position     <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_step_seen    <= 1'b0;
    end else begin
      r_period_valid <= w_period_upd;
      r_step_seen    <= w_accept;
      if (w_accept)
        r_position <= w_pos_next;
      else if (clr_pos)
        r_position <= '0;
      if (w_period_upd)
        r_period <= r_cnt;
    end
  end

  // Stall and glitch flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall      <= 1'b0;
      r_glitch_err <= 1'b0;
    end else begin
      if (!r_en_s2 || w_accept)
        r_stall <= 1'b0;
      else if (w_timeout)
        r_stall <= 1'b1;
      if (w_fall && r_en_s2 && w_short)
        r_glitch_err <= 1'b1;
    end
  end

`ifdef TR_STEP_MON_DIR_CHECK_EN
  localparam int DW = $clog2(DIR_SETUP + 2);

  logic          r_dir_s3;
  logic [DW-1:0] r_dir_age;
  logic [DW-1:0] w_dir_age;
  logic          w_dir_chg;
  logic          r_dir_err;

  assign w_dir_chg = r_dir_s2 ^ r_dir_s3;
  assign w_dir_age = w_dir_chg ? '0 : r_dir_age;

  // Delayed direction copy for change detection.
  always_ff @(posedge clk) begin
    r_dir_s3 <= r_dir_s2;
  end

  // Cycles the current direction has been stable, saturating at DIR_SETUP.
  always_ff @(posedge clk) begin
    if (rst)
      r_dir_age <= DW'(DIR_SETUP);
    else if (w_dir_chg)
      r_dir_age <= DW'(1);
    else if (r_dir_age < DW'(DIR_SETUP))
      r_dir_age <= r_dir_age + DW'(1);
  end

  // Sticky flag for an accepted edge arriving too soon after a direction change.
  always_ff @(posedge clk) begin
    if (rst)
      r_dir_err <= 1'b0;
    else if (w_accept && (w_dir_age < DW'(DIR_SETUP)))
      r_dir_err <= 1'b1;
  end

  assign dir_err = r_dir_err;
`else
  assign dir_err = 1'b0;
`endif

  assign position     = r_position;
  assign period_out   = r_period;
  assign period_valid = r_period_valid;
  assign step_seen    = r_step_seen;
  assign stall        = r_stall;
  assign glitch_err   = r_glitch_err;

endmodule

// File: tb/tb_tr_step_monitor.sv
// Testbench for tr_step_monitor: directed scenarios plus a randomized train,
// every cycle compared against a behavioural model built from edge times.
module tb_tr_step_monitor;

  localparam int PERIOD_W  = 17;
  localparam int POS_W     = 32;
  localparam int TO        = 2000;
  localparam int MIN_HIGH  = 2;
  localparam int DIR_SETUP = 4;
  localparam int NEG_INF   = -1000000;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       drv_step = 1'b0;
  logic                       drv_dir = 1'b0;
  logic                       drv_en_SM = 1'b0;
  logic                       clr_pos = 1'b0;
  logic signed [POS_W-1:0]    position;
  logic        [PERIOD_W-1:0] period_out;
  logic                       period_valid, step_seen, stall, glitch_err, dir_err;

  tr_step_monitor #(
    .PERIOD_W(PERIOD_W), .POS_W(POS_W), .TIMEOUT(TO),
    .MIN_HIGH(MIN_HIGH), .DIR_SETUP(DIR_SETUP)
  ) u_dut (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_en_SM(drv_en_SM), .clr_pos(clr_pos), .position(position),
    .period_out(period_out), .period_valid(period_valid), .step_seen(step_seen),
    .stall(stall), .glitch_err(glitch_err), .dir_err(dir_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pv_cnt = 0;

  // Reference model state: pin history (k-1..k-3) and edge-time bookkeeping.
  int k = 0;
  logic h_st[1:3]  = '{1'b0, 1'b0, 1'b0};
  logic h_dir[1:3] = '{1'b0, 1'b0, 1'b0};
  logic h_en[1:2]  = '{1'b0, 1'b0};
  bit   active = 0, have_last = 0;
  int   last_edge = 0, rise_k = NEG_INF, last_chg = NEG_INF;
  logic signed [POS_W-1:0]    m_pos = '0;
  logic        [PERIOD_W-1:0] m_per = '0;
  logic m_pv = 0, m_ss = 0, m_stall = 0, m_glitch = 0, m_dir_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural update for the clock edge just taken.
  task automatic model_step();
    logic s2, s3, en_s, dir_s, rise, fall, chg, accept;
    int age;
    s2 = h_st[2]; s3 = h_st[3]; en_s = h_en[2]; dir_s = h_dir[2];
    rise = s2 & ~s3;
    fall = ~s2 & s3;
    chg  = h_dir[2] ^ h_dir[3];
    accept = 1'b0;
    if (rst) begin
      m_pos = '0; m_per = '0; m_pv = 0; m_ss = 0;
      m_stall = 0; m_glitch = 0; m_dir_err = 0;
      active = 0; have_last = 0; last_chg = NEG_INF;
    end else begin
      m_pv = 0; m_ss = 0;
      if (!en_s) begin
        active = 0; have_last = 0; m_stall = 0;
      end else if (!active) begin
        active = 1; have_last = 0;
      end else if (rise) begin
        accept = 1'b1;
      end else if (have_last && !m_stall && (k - last_edge) == TO) begin
        m_stall = 1;
      end
      if (accept) begin
        m_pos = (clr_pos ? 0 : m_pos) + (dir_s ? 1 : -1);
        m_ss = 1;
        if (have_last && !m_stall) begin
          m_per = PERIOD_W'(k - last_edge);
          m_pv = 1;
        end
        m_stall = 0; have_last = 1; last_edge = k;
        age = chg ? 0 : k - last_chg;
`ifdef TR_STEP_MON_DIR_CHECK_EN
        if (age < DIR_SETUP) m_dir_err = 1;
`endif
      end else if (clr_pos) begin
        m_pos = '0;
      end
      if (fall && en_s && (k - rise_k) < MIN_HIGH) m_glitch = 1;
      if (chg) last_chg = k;
    end
    if (rise) rise_k = k;
    h_st[3] = h_st[2]; h_st[2] = h_st[1]; h_st[1] = drv_step;
    h_dir[3] = h_dir[2]; h_dir[2] = h_dir[1]; h_dir[1] = drv_dir;
    h_en[2] = h_en[1]; h_en[1] = drv_en_SM;
    k++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (period_valid) pv_cnt++;
    chk("position",     longint'(position), longint'(m_pos));
    chk("period_out",   period_out,   m_per);
    chk("period_valid", period_valid, m_pv);
    chk("step_seen",    step_seen,    m_ss);
    chk("stall",        stall,        m_stall);
    chk("glitch_err",   glitch_err,   m_glitch);
    chk("dir_err",      dir_err,      m_dir_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input int hi, input int lo);
    drv_step = 1'b1;
    idle(hi);
    drv_step = 1'b0;
    idle(lo);
  endtask

  initial begin
    logic signed [POS_W-1:0] p0;
    // Reset state
    idle(5);
    chk("rst_position", longint'(position), 0);
    chk("rst_period", period_out, 0);
    chk("rst_flags", {stall, glitch_err, dir_err, step_seen, period_valid}, 0);
    rst = 1'b0;

    // 1: ten steps, period 1000, high 5
    drv_en_SM = 1'b1; drv_dir = 1'b1;
    idle(10);
    pv_cnt = 0;
    for (int i = 0; i < 10; i++) pulse(5, 995);
    chk("t1_position", longint'(position), 10);
    chk("t1_period", period_out, 1000);
    chk("t1_pv_count", pv_cnt, 9);

    // 2: reverse, clear, 3 steps, then clear coincident with 4th edge
    drv_dir = 1'b0;
    clr_pos = 1'b1; cycle(); clr_pos = 1'b0;
    idle(10);
    for (int i = 0; i < 3; i++) pulse(5, 20);
    chk("t2_pos_m3", longint'(position), -3);
    drv_step = 1'b1;
    idle(2);
    clr_pos = 1'b1; cycle(); clr_pos = 1'b0;
    idle(2);
    drv_step = 1'b0;
    idle(20);
    chk("t2_pos_m1", longint'(position), -1);

    // 3: stall after TIMEOUT idle cycles, cleared by next edge without period_valid
    pulse(5, 5);
    pv_cnt = 0;
    idle(TO);
    chk("t3_stall_set", stall, 1);
    pulse(5, 20);
    chk("t3_stall_clr", stall, 0);
    chk("t3_no_pv", pv_cnt, 0);

    // 4: 1-cycle step pulse -> glitch, still counted
    drv_dir = 1'b1;
    idle(10);
    p0 = position;
    pulse(1, 20);
    chk("t4_glitch", glitch_err, 1);
    chk("t4_position", longint'(position), longint'(p0) + 1);

    // 5: disable mid-train, re-enable restarts in FIRST
    rst = 1'b1; idle(3); rst = 1'b0;
    idle(10);
    for (int i = 0; i < 5; i++) pulse(5, 30);
    chk("t5_pos5", longint'(position), 5);
    drv_en_SM = 1'b0;
    idle(10);
    for (int i = 0; i < 3; i++) pulse(5, 30);
    chk("t5_pos_held", longint'(position), 5);
    drv_en_SM = 1'b1;
    idle(10);
    pv_cnt = 0;
    pulse(5, 30);
    chk("t5_pos6", longint'(position), 6);
    chk("t5_no_pv", pv_cnt, 0);

    // 6: direction change only 2 cycles before a step
    drv_dir = 1'b0;
    idle(2);
    pulse(5, 30);
`ifdef TR_STEP_MON_DIR_CHECK_EN
    chk("t6_dir_err", dir_err, 1);
`else
    chk("t6_dir_err", dir_err, 0);
`endif
    chk("t6_pos5", longint'(position), 5);

    // Randomized trains with random enable, direction, clear and reset events
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) drv_en_SM = ~drv_en_SM;
      if ($urandom_range(0, 3) == 0) drv_dir = ~drv_dir;
      drv_step = 1'b1;
      idle($urandom_range(1, 6));
      drv_step = 1'b0;
      for (int j = $urandom_range(1, 40); j > 0; j--) begin
        clr_pos = ($urandom_range(0, 19) == 0);
        cycle();
      end
      clr_pos = 1'b0;
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
